prod_scale: RTL and testbench
=============================

PROD_SCALE -- requirements
Module: prod_scale

Purpose: downstream stage of the 32x32 multiplier. Takes the 64-bit unsigned product, then shifts it right by a runtime amount, rounds it, and saturates it to OUT_W bits.

Interface
REQ-001 Parameters SHALL be:
- PROD_W, default 64, product width.
- OUT_W, default 32, output width; saturation value is 2^OUT_W-1.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, sole clock; all state updates on the rising edge.
- reset, in, 1, synchronous active-low reset; 0 at a rising edge resets.
- start, in, 1, qualifies prod/shamt; driven by the multiplier done.
- prod, in, PROD_W, unsigned product.
- shamt, in, 6, right-shift amount, 0..63.
- busy, out, 1, operation in progress.
- result, out, OUT_W, scaled, rounded, saturated value.
- overflow, out, 1, last result saturated.
- done, out, 1, one-cycle completion pulse.

Function
REQ-003 The FSM SHALL have states IDLE, SHIFT and ROUND.
REQ-004 In IDLE, start=1 at edge E0 SHALL:
- capture prod into acc, shamt into cnt, and clear rbit;
- set busy=1;
- go to SHIFT if shamt!=0, else to ROUND.
REQ-005 start SHALL be ignored in SHIFT and ROUND; operands are not re-captured and no error is flagged.
REQ-006 Each SHIFT cycle SHALL:
- set rbit <= acc[0];
- logically shift acc right by 1 with zero fill;
- decrement cnt.
It SHALL go to ROUND on the edge where cnt decrements from 1 to 0.
REQ-007 In ROUND, sum = acc + rbit SHALL be computed at PROD_W+1 bits (round half up).
REQ-008 In ROUND, if sum > 2^OUT_W-1:
- result <= 2^OUT_W-1 and overflow <= 1;
- otherwise result <= sum[OUT_W-1:0] and overflow <= 0.
REQ-009 The ROUND edge SHALL also set done <= 1, busy <= 0 and state <= IDLE.
REQ-010 done SHALL be high for exactly one cycle, then clear on the next edge.
REQ-011 Latency: with start sampled at edge E0, result/overflow/done SHALL update at edge E0+shamt+1. Examples: shamt=0 updates at E0+1; shamt=63 updates at E0+64.
REQ-012 result and overflow SHALL hold their values until the next ROUND edge or reset.
REQ-013 start=1 in the cycle where done=1 (state IDLE) SHALL be accepted, giving back-to-back operation with no idle gap.
REQ-014 Changes on prod/shamt after capture SHALL NOT affect the operation in flight.
REQ-015 busy SHALL equal (state != IDLE), registered.

Reset
REQ-016 reset=0 at any edge SHALL:
- set state=IDLE;
- clear busy, done, overflow, result, acc, cnt and rbit to 0.
This holds in every state, including mid-SHIFT and in ROUND.
REQ-017 An operation interrupted by reset SHALL produce no done pulse, and no result update beyond the clear.
REQ-018 start=1 coincident with reset=0 SHALL be ignored.
REQ-019 The first start SHALL be accepted on the first edge with reset=1.

Verification
REQ-020 Nominal case: prod=64'd6519193600 (0x1_8493_0000), shamt=16.
- Required: result=99475, overflow=0.
- done pulses once, 17 edges after the start edge; busy=1 for 17 cycles.
REQ-021 Rounding:
- prod=24, shamt=4 -> result=2.
- prod=23, shamt=4 -> result=1.
- prod=8, shamt=4 -> result=1.
All three give overflow=0.
REQ-022 Saturation:
- prod=6519193600, shamt=0 -> result=0xFFFF_FFFF, overflow=1, done at E0+1.
- prod=0x1_FFFF_FFFF, shamt=1 -> round carries out -> result=0xFFFF_FFFF, overflow=1.
- prod=0xFFFF_FFFF_FFFF_FFFF, shamt=63 -> result=2, overflow=0.
REQ-023 Handshake:
- start pulses during busy are ignored, and the result matches the first operands.
- start in the done cycle is accepted, giving two consecutive correct results.
- prod toggled after capture leaves the result unchanged.
REQ-024 Reset mid-operation: reset=0 for 1 cycle while cnt=5.
- Required: all outputs 0 next cycle and no done pulse.
- A following start with prod=24, shamt=4 completes normally with result=2.

Source files
------------

// File: rtl/prod_scale.sv
// Product scaler: shifts the multiplier's product right by a runtime amount,
// rounds half up on the last bit shifted out, and saturates to OUT_W bits.
module prod_scale #(
  parameter int PROD_W = 64,
  parameter int OUT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [PROD_W-1:0] prod,
  input  logic [5:0]        shamt,
  output logic              busy,
  output logic [OUT_W-1:0]  result,
  output logic              overflow,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, SHIFT, ROUND} state_t;

  localparam logic [PROD_W:0] SAT_LIMIT = {{(PROD_W+1-OUT_W){1'b0}}, {OUT_W{1'b1}}};

  state_t            state;
  state_t            state_nx;
  logic [PROD_W-1:0] acc;
  logic [5:0]        cnt;
  logic              rbit;
  logic [PROD_W:0]   sum;

  // One extra bit so a rounding carry out of the top is seen by the saturation test
  assign sum = {1'b0, acc} + {{PROD_W{1'b0}}, rbit};

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (shamt != 6'd0) ? SHIFT : ROUND;
      SHIFT:   if (cnt == 6'd1) state_nx = ROUND;
      ROUND:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      result   <= '0;
      acc      <= '0;
      cnt      <= '0;
      rbit     <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx != IDLE);
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            acc  <= prod;
            cnt  <= shamt;
            rbit <= 1'b0;
          end
        end
        SHIFT: begin
          rbit <= acc[0];
          acc  <= {1'b0, acc[PROD_W-1:1]};
          cnt  <= cnt - 6'd1;
        end
        ROUND: begin
          done <= 1'b1;
          if (sum > SAT_LIMIT) begin
            result   <= '1;
            overflow <= 1'b1;
          end else begin
            result   <= sum[OUT_W-1:0];
            overflow <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prod_scale.sv
// Directed bench for prod_scale: table of vectors plus hand-written sequences
// for back-to-back starts and a reset that lands mid-shift.
module tb_prod_scale;

  logic        clk;
  logic        reset;
  logic        start;
  logic [63:0] prod;
  logic [5:0]  shamt;
  logic        busy;
  logic [31:0] result;
  logic        overflow;
  logic        done;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [63:0] prod;
    logic [5:0]  shamt;
    logic [31:0] res;
    logic        ovf;
    logic        disturb;
  } vec_t;

  vec_t vecs[10];

  prod_scale #(.PROD_W(64), .OUT_W(32)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .prod(prod),
    .shamt(shamt),
    .busy(busy),
    .result(result),
    .overflow(overflow),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Raises start with the given operands, then waits (bounded) for done.
  // edges counts rising edges after the start edge; busyCnt counts samples with busy=1.
  task automatic applyStimulus(input logic [63:0] p, input logic [5:0] s, input logic disturb,
                               output int edges, output int busyCnt);
    prod  = p;
    shamt = s;
    start = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    edges   = 0;
    busyCnt = 0;
    while (!done && edges < 200) begin
      if (busy) busyCnt++;
      if (disturb) begin
        start = 1'($urandom_range(0, 1));
        prod  = {$urandom, $urandom};
        shamt = 6'($urandom);
      end
      @(posedge clk); #1;
      edges++;
    end
    start = 1'b0;
  endtask

  task automatic runChecked(input string name, input logic [63:0] p, input logic [5:0] s,
                            input logic disturb, input logic [31:0] expRes, input logic expOvf);
    int edges;
    int busyCnt;
    applyStimulus(p, s, disturb, edges, busyCnt);
    checkOutput({name, " done"}, 64'(done), 64'd1);
    checkOutput({name, " latency"}, 64'(edges), 64'(s) + 64'd1);
    checkOutput({name, " busy cycles"}, 64'(busyCnt), 64'(s) + 64'd1);
    checkOutput({name, " busy at done"}, 64'(busy), 64'd0);
    checkOutput({name, " result"}, 64'(result), 64'(expRes));
    checkOutput({name, " overflow"}, 64'(overflow), 64'(expOvf));
  endtask

  initial begin
    int doneSeen;

    vecs[0] = '{64'd6519193600,          6'd16, 32'd99475,      1'b0, 1'b0};
    vecs[1] = '{64'd24,                  6'd4,  32'd2,          1'b0, 1'b0};
    vecs[2] = '{64'd23,                  6'd4,  32'd1,          1'b0, 1'b0};
    vecs[3] = '{64'd8,                   6'd4,  32'd1,          1'b0, 1'b0};
    vecs[4] = '{64'd6519193600,          6'd0,  32'hFFFF_FFFF,  1'b1, 1'b0};
    vecs[5] = '{64'h1_FFFF_FFFF,         6'd1,  32'hFFFF_FFFF,  1'b1, 1'b0};
    vecs[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 6'd63, 32'd2,          1'b0, 1'b0};
    vecs[7] = '{64'd6519193600,          6'd16, 32'd99475,      1'b0, 1'b1};
    vecs[8] = '{64'hFFFF_FFFF,           6'd0,  32'hFFFF_FFFF,  1'b0, 1'b0};
    vecs[9] = '{64'h1_0000_0000,         6'd0,  32'hFFFF_FFFF,  1'b1, 1'b0};

    // Reset held with start asserted: start must be ignored
    reset = 1'b0;
    start = 1'b1;
    prod  = 64'd5;
    shamt = 6'd0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset done", 64'(done), 64'd0);
    checkOutput("reset result", 64'(result), 64'd0);
    checkOutput("reset overflow", 64'(overflow), 64'd0);
    reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      runChecked($sformatf("vec%0d", i), vecs[i].prod, vecs[i].shamt, vecs[i].disturb,
                 vecs[i].res, vecs[i].ovf);
      @(posedge clk); #1;
      checkOutput($sformatf("vec%0d done cleared", i), 64'(done), 64'd0);
      checkOutput($sformatf("vec%0d result held", i), 64'(result), 64'(vecs[i].res));
      checkOutput($sformatf("vec%0d overflow held", i), 64'(overflow), 64'(vecs[i].ovf));
    end

    // Back-to-back: second start raised in the done cycle
    runChecked("b2b first", 64'd6519193600, 6'd16, 1'b0, 32'd99475, 1'b0);
    runChecked("b2b second", 64'd24, 6'd4, 1'b0, 32'd2, 1'b0);
    @(posedge clk); #1;
    checkOutput("b2b done cleared", 64'(done), 64'd0);

    // Reset lands while cnt=5, with start asserted alongside it
    prod  = 64'd6519193600;
    shamt = 6'd16;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    checkOutput("midop busy before reset", 64'(busy), 64'd1);
    reset = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    start = 1'b0;
    checkOutput("midop reset busy", 64'(busy), 64'd0);
    checkOutput("midop reset done", 64'(done), 64'd0);
    checkOutput("midop reset result", 64'(result), 64'd0);
    checkOutput("midop reset overflow", 64'(overflow), 64'd0);
    doneSeen = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (done || busy) doneSeen++;
    end
    checkOutput("midop no done after reset", 64'(doneSeen), 64'd0);
    checkOutput("midop result stays clear", 64'(result), 64'd0);
    runChecked("after reset", 64'd24, 6'd4, 1'b0, 32'd2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
